vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001: The block SHALL provide parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002: The block SHALL provide parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003: The block SHALL provide parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004: The block SHALL provide parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005: The block SHALL provide parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006: The block SHALL provide parameter V_FP, default 10, vertical front porch in lines.
REQ-007: The block SHALL provide parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008: The block SHALL provide parameter V_BP, default 33, vertical back porch in lines.
REQ-009: vga_clk  input  1  pixel clock; the only clock.
REQ-010: reset  input  1  asynchronous, active-high reset.
REQ-011: pix_en  input  1  pixel advance qualifier; counters step only when high.
REQ-012: DrawX  output  10  current horizontal pixel coordinate.
REQ-013: DrawY  output  10  current line coordinate.
REQ-014: blank  output  1  high while (DrawX, DrawY) is inside the active region; low otherwise.
REQ-015: hs  output  1  horizontal sync, active low.
REQ-016: vs  output  1  vertical sync, active low.
REQ-017: line_start  output  1  one-cycle pulse when DrawX steps to 0.
REQ-018: frame_start  output  1  one-cycle pulse when (DrawX, DrawY) steps to (0, 0).
REQ-019: frame_count  output  8  count of completed frames, modulo 256.

Function
REQ-020: H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-021: A horizontal region FSM SHALL track states H_ACT (DrawX 0..639), H_FRONT (640..655), H_SYNC (656..751), H_BACK (752..799), advancing on the pix_en cycle in which DrawX reaches the last pixel of the region.
REQ-022: A vertical region FSM SHALL track states V_ACT (0..479), V_FRONT (480..489), V_SYNC (490..491), V_BACK (492..524), advancing only at end of line.
REQ-023: On each vga_clk edge with pix_en=1, DrawX SHALL increment; at DrawX=H_TOTAL-1 it SHALL wrap to 0 and DrawY SHALL increment.
REQ-024: At DrawX=H_TOTAL-1 with DrawY=V_TOTAL-1, both SHALL wrap to 0 and frame_count SHALL increment, wrapping 255->0.
REQ-025: With pix_en=0, DrawX, DrawY, FSM states, frame_count, hs, vs, and blank SHALL hold their values; line_start and frame_start SHALL be 0.
REQ-026: hs, vs, blank, line_start, and frame_start SHALL be registered and SHALL correspond to the DrawX/DrawY values present in the same cycle, with zero combinational paths from pix_en.
REQ-027: hs SHALL be 0 only in H_SYNC; vs SHALL be 0 only in V_SYNC; blank SHALL be 1 only in H_ACT and V_ACT.
REQ-028: frame_start SHALL coincide with a line_start pulse.

Reset
REQ-029: While reset is high, DrawX=0, DrawY=0, FSMs SHALL be in H_ACT/V_ACT, blank=1, hs=1, vs=1, line_start=0, frame_start=0, and frame_count=0.
REQ-030: Reset asserted mid-frame SHALL force the REQ-029 values immediately; the first pix_en cycle after release SHALL give DrawX=1, DrawY=0.

Configuration
REQ-031: When VGA_PIPE_ALIGN_EN is defined, hs and vs SHALL each pass through one additional vga_clk register (unqualified by pix_en, reset value 1) to align with a downstream renderer that registers RGB one cycle after DrawX/DrawY.
REQ-032: When VGA_PIPE_ALIGN_EN is undefined, hs and vs SHALL follow REQ-026 with no extra delay; all other outputs SHALL be identical in both builds.

Verification
REQ-033: Assert reset mid-line at DrawX=300, DrawY=100 -> outputs SHALL match REQ-029 values; after release plus one pix_en, DrawX=1.
REQ-034: Hold pix_en=1 from reset for 656 cycles -> hs=0, blank=0 at DrawX=656; hs SHALL return to 1 at DrawX=752 (96 cycles low).
REQ-035: Step through DrawX=799, DrawY=479 -> next cycle DrawX=0, DrawY=480, line_start=1, blank=0; vs=0 SHALL occur for DrawY 490..491 only.
REQ-036: Run 256 full frames (420000 pix_en cycles each) -> frame_start SHALL pulse once per frame at (0, 0), and frame_count SHALL read 0 after the 256th frame.
REQ-037: Toggle pix_en 1/0 alternately -> DrawX SHALL advance every second cycle, pulses SHALL last exactly one cycle, and outputs SHALL hold during pix_en=0.
REQ-038: With VGA_PIPE_ALIGN_EN defined -> hs falling edge SHALL occur exactly one vga_clk after DrawX becomes 656; undefined -> in the same cycle.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, region FSMs and registered sync/blank/pulse outputs.
// Optional build macro VGA_PIPE_ALIGN_EN adds one vga_clk of delay on hs/vs.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned CW      = 10;
    localparam int unsigned FCW     = 8;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last coordinate of each region; a region FSM advances when the counter sits here.
    localparam logic [CW-1:0] H_ACT_LAST   = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] H_FRONT_LAST = CW'(H_ACTIVE + H_FP - 1);
    localparam logic [CW-1:0] H_SYNC_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_LAST   = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] V_FRONT_LAST = CW'(V_ACTIVE + V_FP - 1);
    localparam logic [CW-1:0] V_SYNC_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);

    typedef enum logic [1:0] {HR_ACT, HR_FRONT, HR_SYNC, HR_BACK} h_state_t;
    typedef enum logic [1:0] {VR_ACT, VR_FRONT, VR_SYNC, VR_BACK} v_state_t;

    logic [CW-1:0]  r_x;
    logic [CW-1:0]  r_y;
    logic [FCW-1:0] r_fc;
    h_state_t       r_h_state;
    v_state_t       r_v_state;
    logic           r_blank;
    logic           r_hs;
    logic           r_vs;
    logic           r_ls;
    logic           r_fs;

    logic           w_eol;
    logic           w_eof;
    logic [CW-1:0]  w_x_next;
    logic [CW-1:0]  w_y_next;
    h_state_t       w_h_next;
    v_state_t       w_v_next;
    logic           w_blank_next;
    logic           w_hs_next;
    logic           w_vs_next;
    logic           w_ls_next;
    logic           w_fs_next;

    assign w_eol    = pix_en && (r_x == H_LAST);
    assign w_eof    = w_eol && (r_y == V_LAST);
    assign w_x_next = w_eol ? '0 : r_x + CW'(1);
    assign w_y_next = w_eof ? '0 : r_y + CW'(1);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_x  <= '0;
            r_y  <= '0;
            r_fc <= '0;
        end else if (pix_en) begin
            r_x <= w_x_next;
            if (w_eol) r_y  <= w_y_next;
            if (w_eof) r_fc <= r_fc + FCW'(1);
        end
    end

    // Region FSM state registers
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_h_state <= HR_ACT;
            r_v_state <= VR_ACT;
        end else begin
            r_h_state <= w_h_next;
            r_v_state <= w_v_next;
        end
    end

    // Next-state logic: leave a region on the step out of its last coordinate
    always_comb begin
        w_h_next = r_h_state;
        w_v_next = r_v_state;
        if (pix_en) begin
            case (r_h_state)
                HR_ACT:   if (r_x == H_ACT_LAST)   w_h_next = HR_FRONT;
                HR_FRONT: if (r_x == H_FRONT_LAST) w_h_next = HR_SYNC;
                HR_SYNC:  if (r_x == H_SYNC_LAST)  w_h_next = HR_BACK;
                HR_BACK:  if (r_x == H_LAST)       w_h_next = HR_ACT;
                default:                           w_h_next = HR_ACT;
            endcase
        end
        if (w_eol) begin
            case (r_v_state)
                VR_ACT:   if (r_y == V_ACT_LAST)   w_v_next = VR_FRONT;
                VR_FRONT: if (r_y == V_FRONT_LAST) w_v_next = VR_SYNC;
                VR_SYNC:  if (r_y == V_SYNC_LAST)  w_v_next = VR_BACK;
                VR_BACK:  if (r_y == V_LAST)       w_v_next = VR_ACT;
                default:                           w_v_next = VR_ACT;
            endcase
        end
    end

    // Output decode from the next state so the registered outputs line up with DrawX/DrawY
    always_comb begin
        w_blank_next = 1'b0;
        w_hs_next    = 1'b1;
        w_vs_next    = 1'b1;
        w_ls_next    = 1'b0;
        w_fs_next    = 1'b0;
        w_blank_next = (w_h_next == HR_ACT) && (w_v_next == VR_ACT);
        w_hs_next    = (w_h_next != HR_SYNC);
        w_vs_next    = (w_v_next != VR_SYNC);
        w_ls_next    = w_eol;
        w_fs_next    = w_eof;
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_blank <= 1'b1;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_ls    <= 1'b0;
            r_fs    <= 1'b0;
        end else begin
            r_blank <= w_blank_next;
            r_hs    <= w_hs_next;
            r_vs    <= w_vs_next;
            r_ls    <= w_ls_next;
            r_fs    <= w_fs_next;
        end
    end

`ifdef VGA_PIPE_ALIGN_EN
    logic r_hs_d;
    logic r_vs_d;

    // Free-running delay stage matching a renderer that registers RGB one clock late
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_hs_d <= 1'b1;
            r_vs_d <= 1'b1;
        end else begin
            r_hs_d <= r_hs;
            r_vs_d <= r_vs;
        end
    end

    assign hs = r_hs_d;
    assign vs = r_vs_d;
`else
    assign hs = r_hs;
    assign vs = r_vs;
`endif

    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign blank       = r_blank;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
    assign frame_count = r_fc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default-size instance for line timing and a
// reduced-size instance for full-frame, mid-frame reset and 256-frame wrap behaviour.
module tb_vga_timing_gen;

`ifdef VGA_PIPE_ALIGN_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    typedef struct {
        int ha; int hf; int hsw; int hb;
        int va; int vf; int vsw; int vb;
    } cfg_t;

    typedef struct {
        int x; int y; int fc;
        bit hs; bit vs; bit blank; bit ls; bit fs;
        bit hs_d; bit vs_d;
    } mstate_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } out_t;

    localparam cfg_t CFG_BIG = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam cfg_t CFG_SML = '{8, 2, 3, 2, 6, 1, 2, 2};
    localparam int   SML_FRAME = 15 * 11;

    logic       vga_clk = 1'b0;
    logic       reset;
    logic       pix_en;
    logic [9:0] b_x, b_y, s_x, s_y;
    logic       b_blank, b_hs, b_vs, b_ls, b_fs;
    logic       s_blank, s_hs, s_vs, s_ls, s_fs;
    logic [7:0] b_fc, s_fc;

    int n_checks = 0;
    int n_fail   = 0;

    mstate_t m_big, m_sml;
    out_t    q_big[$];
    out_t    q_sml[$];

    bit f656, f657, f752, fline, fvact;
    int hs_low_cnt;
    int fs_cnt;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen u_big (
        .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
        .DrawX(b_x), .DrawY(b_y), .blank(b_blank), .hs(b_hs), .vs(b_vs),
        .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_sml (
        .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
        .DrawX(s_x), .DrawY(s_y), .blank(s_blank), .hs(s_hs), .vs(s_vs),
        .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic mstate_t reset_state();
        mstate_t n;
        n.x = 0; n.y = 0; n.fc = 0;
        n.hs = 1'b1; n.vs = 1'b1; n.blank = 1'b1; n.ls = 1'b0; n.fs = 1'b0;
        n.hs_d = 1'b1; n.vs_d = 1'b1;
        return n;
    endfunction

    // Reference model: one vga_clk edge of the raster, outputs derived from coordinate ranges
    function automatic mstate_t step(mstate_t s, cfg_t c, bit r, bit pe);
        mstate_t n;
        int ht, vt, hs0, vs0;
        if (r) return reset_state();
        n = s;
        ht  = c.ha + c.hf + c.hsw + c.hb;
        vt  = c.va + c.vf + c.vsw + c.vb;
        hs0 = c.ha + c.hf;
        vs0 = c.va + c.vf;
        n.hs_d = s.hs;
        n.vs_d = s.vs;
        n.ls   = 1'b0;
        n.fs   = 1'b0;
        if (pe) begin
            if (s.x == ht - 1) begin
                n.x  = 0;
                n.ls = 1'b1;
                if (s.y == vt - 1) begin
                    n.y  = 0;
                    n.fs = 1'b1;
                    n.fc = (s.fc + 1) % 256;
                end else begin
                    n.y = s.y + 1;
                end
            end else begin
                n.x = s.x + 1;
            end
            n.hs    = !(n.x >= hs0 && n.x < hs0 + c.hsw);
            n.vs    = !(n.y >= vs0 && n.y < vs0 + c.vsw);
            n.blank = (n.x < c.ha) && (n.y < c.va);
        end
        return n;
    endfunction

    function automatic out_t expect_of(mstate_t m);
        out_t o;
        o.x     = 10'(m.x);
        o.y     = 10'(m.y);
        o.blank = m.blank;
        o.hs    = PIPE ? m.hs_d : m.hs;
        o.vs    = PIPE ? m.vs_d : m.vs;
        o.ls    = m.ls;
        o.fs    = m.fs;
        o.fc    = 8'(m.fc);
        return o;
    endfunction

    task automatic sample();
        out_t ob, os, eb, es;
        ob = '{b_x, b_y, b_blank, b_hs, b_vs, b_ls, b_fs, b_fc};
        os = '{s_x, s_y, s_blank, s_hs, s_vs, s_ls, s_fs, s_fc};
        if (q_big.size() == 0 || q_sml.size() == 0) begin
            check_eq("sb_empty", 64'(q_big.size() + q_sml.size()), 64'd2);
            return;
        end
        eb = q_big.pop_front();
        es = q_sml.pop_front();
        check_eq("big_out", 64'(ob), 64'(eb));
        check_eq("sml_out", 64'(os), 64'(es));

        // Line-0 sync timing on the default-size instance
        if (ob.y == 0 && !ob.hs && !fline) hs_low_cnt++;
        if (ob.y == 0 && ob.x == 656 && !f656) begin
            f656 = 1'b1;
            check_eq("hs_at_656", 64'(ob.hs), PIPE ? 64'd1 : 64'd0);
            check_eq("blank_at_656", 64'(ob.blank), 64'd0);
        end
        if (ob.y == 0 && ob.x == 657 && !f657) begin
            f657 = 1'b1;
            check_eq("hs_at_657", 64'(ob.hs), 64'd0);
        end
        if (ob.y == 0 && ob.x == 752 && !f752) begin
            f752 = 1'b1;
            check_eq("hs_at_752", 64'(ob.hs), PIPE ? 64'd0 : 64'd1);
        end
        if (ob.y == 1 && ob.x == 0 && !fline) begin
            fline = 1'b1;
            check_eq("hs_low_cycles", 64'(hs_low_cnt), 64'd96);
        end

        // Frame/line pulse relationships on the reduced instance
        if (os.fs) begin
            fs_cnt++;
            check_eq("fs_with_ls", 64'(os.ls), 64'd1);
            check_eq("fs_at_origin", 64'({os.x, os.y}), 64'd0);
        end
        if (os.ls && os.x == 0 && os.y == 6 && !fvact) begin
            fvact = 1'b1;
            check_eq("blank_after_vact", 64'(os.blank), 64'd0);
        end
    endtask

    task automatic cycle(input bit r, input bit pe);
        reset  = r;
        pix_en = pe;
        m_big = step(m_big, CFG_BIG, r, pe);
        m_sml = step(m_sml, CFG_SML, r, pe);
        q_big.push_back(expect_of(m_big));
        q_sml.push_back(expect_of(m_sml));
        @(posedge vga_clk);
        @(negedge vga_clk);
        sample();
    endtask

    initial begin
        bit reached;
        reset  = 1'b1;
        pix_en = 1'b0;
        m_big  = reset_state();
        m_sml  = reset_state();
        f656 = 0; f657 = 0; f752 = 0; fline = 0; fvact = 0;
        hs_low_cnt = 0;
        fs_cnt = 0;

        repeat (3) cycle(1'b1, 1'b1);
        check_eq("rst_x", 64'(b_x), 64'd0);
        check_eq("rst_y", 64'(b_y), 64'd0);
        check_eq("rst_blank", 64'(b_blank), 64'd1);
        check_eq("rst_hs", 64'(b_hs), 64'd1);
        check_eq("rst_vs", 64'(b_vs), 64'd1);
        check_eq("rst_pulses", 64'({b_ls, b_fs}), 64'd0);
        check_eq("rst_fc", 64'(b_fc), 64'd0);

        // Continuous run through the first lines of the default instance
        repeat (1700) cycle(1'b0, 1'b1);

        // Alternating qualifier
        for (int i = 0; i < 400; i++) cycle(1'b0, i[0] == 1'b0);

        // Random qualifier
        repeat (600) cycle(1'b0, $urandom_range(0, 3) != 0);

        // Mid-frame reset on the reduced instance at (5, 3)
        reached = 1'b0;
        for (int i = 0; i < 2 * SML_FRAME && !reached; i++) begin
            if (m_sml.x == 5 && m_sml.y == 3) reached = 1'b1;
            else cycle(1'b0, 1'b1);
        end
        check_eq("reach_mid", 64'(reached), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("async_rst_sml", 64'({s_x, s_y, s_blank, s_hs, s_vs, s_ls, s_fs, s_fc}),
                 64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}));
        check_eq("async_rst_big_x", 64'(b_x), 64'd0);
        repeat (2) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        check_eq("post_rst_x", 64'(s_x), 64'd1);
        check_eq("post_rst_y", 64'(s_y), 64'd0);

        // 256 complete frames of the reduced instance
        repeat (2) cycle(1'b1, 1'b0);
        fs_cnt = 0;
        repeat (256 * SML_FRAME) cycle(1'b0, 1'b1);
        check_eq("frame_pulses", 64'(fs_cnt), 64'd256);
        check_eq("fc_wrap", 64'(s_fc), 64'd0);
        check_eq("end_origin", 64'({s_x, s_y}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
